// File: rtl/max_pool_ctrl.sv
// Signed KxK/stride-K max pooling over a row-major feature map; K-1 row line buffer.
// Result registered one cycle after the window-completing pixel; input stalls while an unaccepted result is held.
module max_pool2d #(
  parameter int K     = 2,
  parameter int WIDTH = 8
) (
  input  logic [K*K-1:0][WIDTH-1:0] win,
  output logic [WIDTH-1:0]          pool_max
);
  always_comb begin
    pool_max = win[0];
    for (int i = 1; i < K*K; i++) begin
      if ($signed(win[i]) > $signed(pool_max)) pool_max = win[i];
    end
  end
endmodule

module max_pool_ctrl #(
  parameter int K     = 2,
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KW  = $clog2(K);
  localparam int LBN = (K-1)*IMG_W;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [KW-1:0] col_k, row_k;

  logic [WIDTH-1:0] lbuf [LBN];
  logic [WIDTH-1:0] sr   [K-1];

  logic [K*K-1:0][WIDTH-1:0] win;
  logic [WIDTH-1:0]          pool_max;
  logic                      accept, emit, last_px;
  logic [LBW-1:0]            wr_idx;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (row_k == KW'(K-1)) && (col_k == KW'(K-1));
  assign last_px  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign wr_idx   = LBW'(int'(row_k)*IMG_W + int'(col));

  // Upper rows come from the line buffer, the bottom row from the shift register plus the live pixel.
  always_comb begin
    win = '0;
    for (int ky = 0; ky < K-1; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        win[ky*K+kx] = lbuf[LBW'(ky*IMG_W + kx + int'(col) - (K-1))];
      end
    end
    for (int kx = 0; kx < K-1; kx++) win[(K-1)*K+kx] = sr[kx];
    win[K*K-1] = in_data;
  end

  max_pool2d #(.K(K), .WIDTH(WIDTH)) u_pool (
    .win      (win),
    .pool_max (pool_max)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      if (row_k != KW'(K-1)) lbuf[wr_idx] <= in_data;
      for (int i = 0; i < K-2; i++) sr[i] <= sr[i+1];
      sr[K-2] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      col_k     <= '0;
      row_k     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            col   <= '0;
            row   <= '0;
            col_k <= '0;
            row_k <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == CW'(IMG_W-1)) begin
              col   <= '0;
              col_k <= '0;
              if (row == RW'(IMG_H-1)) begin
                row   <= '0;
                row_k <= '0;
              end else begin
                row   <= row + 1'b1;
                row_k <= (row_k == KW'(K-1)) ? '0 : row_k + 1'b1;
              end
            end else begin
              col   <= col + 1'b1;
              col_k <= (col_k == KW'(K-1)) ? '0 : col_k + 1'b1;
            end
            if (emit) begin
              out_valid <= 1'b1;
              out_data  <= pool_max;
              out_last  <= last_px;
            end
            if (last_px) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed bench for max_pool_ctrl with K=2 on a 4x4 map; inputs driven on the falling edge.
module tb_max_pool_ctrl;
  localparam int K = 2, WIDTH = 8, IMG_W = 4, IMG_H = 4;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid, out_last, busy, done;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  max_pool_ctrl #(.K(K), .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pix(input int mode, input int p);
    return (mode == 1) ? -(p + 1) : p;
  endfunction

  // mode: 0 basic, 1 signed, 2 backpressure, 3 input bubbles, 4 start during RUN
  task automatic run_frame(input int mode, input string tag);
    int exp_d[4];
    int od[4];
    int ol[4];
    int p = 0, n = 0, dn = 0, cyc = 0, bp = 0, cap_d = 0, cap_l = 0;
    bit seen_done = 1'b0;
    if (mode == 1) begin
      exp_d[0] = -1; exp_d[1] = -3; exp_d[2] = -9; exp_d[3] = -11;
    end else begin
      exp_d[0] = 5;  exp_d[1] = 7;  exp_d[2] = 13; exp_d[3] = 15;
    end
    for (int i = 0; i < 4; i++) begin od[i] = 0; ol[i] = 0; end

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      start     = (mode == 4) && (p == 3);
      in_valid  = (p < 16) && ((mode != 3) || ($urandom_range(0, 1) == 1));
      in_data   = WIDTH'(pix(mode, (p < 16) ? p : 0));
      out_ready = (mode != 2) || (bp >= 3);
      #1;
      if (done) begin dn++; seen_done = 1'b1; end
      if (mode == 2 && out_valid && bp < 3) begin
        check({tag, "_bp_in_ready"}, int'(in_ready), 0);
        if (bp == 0) begin
          cap_d = int'($signed(out_data));
          cap_l = int'(out_last);
        end else begin
          check({tag, "_bp_data_hold"}, int'($signed(out_data)), cap_d);
          check({tag, "_bp_last_hold"}, int'(out_last), cap_l);
        end
        bp++;
      end
      if (out_valid && out_ready) begin
        if (n < 4) begin
          od[n] = int'($signed(out_data));
          ol[n] = int'(out_last);
          if (mode != 1) check({tag, "_no_early_out"}, int'(p > od[n]), 1);
        end
        n++;
      end
      if (in_valid && in_ready) p++;
      cyc++;
    end
    if (!seen_done) check({tag, "_timeout"}, cyc, -1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (done) dn++;
      check({tag, "_idle_in_ready"}, int'(in_ready), 0);
    end
    check({tag, "_out_count"}, n, 4);
    check({tag, "_in_count"}, p, 16);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), od[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), ol[i], (i == 3) ? 1 : 0);
    end
    check({tag, "_done_pulses"}, dn, 1);
    check({tag, "_busy_after"}, int'(busy), 0);
    if (mode == 2) check({tag, "_bp_cycles"}, bp, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_out_last",  int'(out_last), 0);
    check("rst_in_ready",  int'(in_ready), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);

    // No start: a valid pixel must sit unconsumed.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("nostart_in_ready", int'(in_ready), 0);
      check("nostart_busy", int'(busy), 0);
    end
    in_valid = 1'b0;

    run_frame(0, "basic");
    run_frame(1, "signed");
    run_frame(2, "bp");
    run_frame(3, "bubbles");
    run_frame(4, "start_in_run");

    // Reset mid-frame after 6 pixels; pixel 5 leaves a pending window result.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      in_valid = 1'b1; in_data = WIDTH'(p); out_ready = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("mid_pending_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data",  int'(out_data), 0);
    check("midrst_out_last",  int'(out_last), 0);
    check("midrst_in_ready",  int'(in_ready), 0);
    check("midrst_busy",      int'(busy), 0);
    check("midrst_done",      int'(done), 0);
    rst = 1'b0; out_ready = 1'b1;
    run_frame(0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/max_pool_ctrl.md
# max_pool_ctrl

Streaming controller that sequences the combinational `max_pool2d` datapath over a full feature map. It accepts pixels in row-major order over a valid/ready stream and buffers K-1 rows. It assembles each non-overlapping KxK window (stride K), drives it into an internal `max_pool2d` instance and returns the pooled pixels on a registered valid/ready output stream. It sits between a conv/activation stage and the next layer's input FIFO.

## Interface
- `K`, 2: window size and stride; IMG_W and IMG_H must be multiples of K.
- `WIDTH`, 8: pixel width, two's-complement signed.
- `IMG_W`, 8: input feature-map width in pixels.
- `IMG_H`, 8: input feature-map height in pixels.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  controller can accept a pixel.
- `in_data`  in  WIDTH  input pixel, signed.
- `out_valid`  out  1  pooled pixel valid.
- `out_ready`  in  1  downstream accepts a pooled pixel.
- `out_data`  out  WIDTH  pooled pixel (signed max of window).
- `out_last`  out  1  qualifies the final pooled pixel of a frame.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last output is accepted.

## Operation
- FSM states:
  - IDLE: `in_ready`=0; `start` resets col/row counters and moves to RUN.
  - RUN: accepts pixels. After the last input pixel (row IMG_H-1, col IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: `in_ready`=0. When the final output handshake completes (`out_valid & out_ready & out_last`), pulse `done` and return to IDLE.
- An input pixel is accepted when `in_valid & in_ready`. Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on acceptance. `col` wraps to 0 and increments `row`.
- Line buffer holds (K-1)*IMG_W pixels. A pixel with row%K != K-1 is written at index (row%K)*IMG_W+col.
- A shift register of K-1 pixels holds the previous pixels of the current row.
- Window emission happens on acceptance of a pixel with row%K==K-1 and col%K==K-1:
  - Window element ky*K+kx is the line-buffer entry ky*IMG_W+(col-K+1+kx) for ky<K-1.
  - For ky=K-1 it is the shift-register/current pixel.
  - The window drives the `max_pool2d` instance. The result is registered into `out_data` with `out_valid`=1.
  - `out_last`=1 iff row==IMG_H-1 and col==IMG_W-1.
- Comparison is signed. Ties are irrelevant because the value is identical. No widening or saturation: the output width is WIDTH.
- Output register is a single stage. `in_ready` = (state==RUN) & (!out_valid | out_ready), so an emitting pixel can never overwrite an unaccepted result.
- `start` in RUN or DRAIN is ignored.
- `in_valid` with `in_ready`=0 is not consumed; the data must be held by the source.

## Timing
- Reset values:
  - state=IDLE; counters=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `in_ready`=0, `busy`=0, `done`=0.
  - Line-buffer contents are don't-care.
- `start` at cycle t: state=RUN and `in_ready` can be high at t+1.
- Latency: window-completing pixel accepted at cycle t gives `out_valid`=1 at t+1.
- `out_data` and `out_last` are stable while `out_valid & !out_ready`.
- Throughput is one pixel per cycle with `out_ready` held high.
- Output and new-input on the same cycle: an output handshake and an input acceptance may occur together. If that input completes a window, `out_valid` stays 1 with new data at the next cycle.
- `done` is asserted in the cycle after the final output handshake. `busy` falls in that same cycle.
- `rst` mid-frame returns to IDLE next cycle and drops any pending output. Pixels already buffered are discarded.

## Test plan
- Basic: K=2, IMG_W=IMG_H=4, pixels 0..15 row-major, `out_ready`=1 -> outputs 5,7,13,15. `out_last` only on 15. `done` pulses once, then IDLE.
- Signed: same geometry, pixel i = -(i+1) -> outputs -1,-3,-9,-11.
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1 -> `out_data` and `out_last` are unchanged and `in_ready`=0 throughout. On release, the output sequence is identical to the basic case.
- Input bubbles: randomly deassert `in_valid` (~50%) with pixels 0..15 -> same outputs 5,7,13,15; no output occurs before its 4th window pixel is accepted.
- Start/state rules: `start` pulsed during RUN is ignored and the frame completes normally. With no `start`, `in_ready` stays 0 and no pixel is consumed.
- Reset mid-frame: assert `rst` after 6 pixels -> next cycle all outputs are at reset values. A new `start` plus pixels 0..15 gives 5,7,13,15.
